// File: rtl/exunit_alu_pkg.sv
// Shared constants, ALU op codes and pipeline bundles
// for the ALU execution unit.
package exunit_alu_pkg;

  localparam int DATA_LEN     = 32;
  localparam int ADDR_LEN     = 32;
  localparam int RRF_SEL      = 6;
  localparam int ALU_OP_WIDTH = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SLL  = 4'h1,
    ALU_SLT  = 4'h2,
    ALU_SLTU = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SRL  = 4'h5,
    ALU_OR   = 4'h6,
    ALU_AND  = 4'h7,
    ALU_SUB  = 4'h8,
    ALU_SRA  = 4'hD
  } alu_op_e;

  typedef struct packed {
    logic [ADDR_LEN-1:0]     pc;
    logic [DATA_LEN-1:0]     op_1;
    logic [DATA_LEN-1:0]     op_2;
    logic [DATA_LEN-1:0]     imm;
    logic                    src_a_sel;
    logic                    src_b_sel;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [RRF_SEL-1:0]      rrf_tag;
    logic                    we_dst;
  } ex_t;

  typedef struct packed {
    logic [DATA_LEN-1:0] result;
    logic [RRF_SEL-1:0]  rrf_tag;
    logic                we_dst;
  } res_t;

endpackage

// File: rtl/alu_core.sv
// Pure combinational integer ALU shared by
// execution units; unknown op codes yield zero.
module alu_core
  import exunit_alu_pkg::*;
(
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_LEN-1:0]     a,
  input  logic [DATA_LEN-1:0]     b,
  output logic [DATA_LEN-1:0]     result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  // Operation select
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(DATA_LEN-1){1'b0}},
                          $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(DATA_LEN-1){1'b0}}, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/exunit_alu.sv
// Two-stage ALU execution unit: EX operand register,
// ALU, RES register broadcasting on the CDB.
module exunit_alu
  import exunit_alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [ADDR_LEN-1:0]     issue_pc_i,
  input  logic [DATA_LEN-1:0]     issue_op_1_i,
  input  logic [DATA_LEN-1:0]     issue_op_2_i,
  input  logic [DATA_LEN-1:0]     issue_imm_i,
  input  logic                    issue_src_a_sel_i,
  input  logic                    issue_src_b_sel_i,
  input  logic [ALU_OP_WIDTH-1:0] issue_alu_op_i,
  input  logic [RRF_SEL-1:0]      issue_rrf_tag_i,
  input  logic                    issue_is_write_dst_i,
  input  logic                    kill_i,
  output logic                    cdb_valid_o,
  output logic [DATA_LEN-1:0]     cdb_result_o,
  output logic [RRF_SEL-1:0]      cdb_rrf_tag_o,
  output logic                    cdb_we_dst_o,
  input  logic                    cdb_grant_i
);

  logic ex_v_q, ex_v_d;
  logic res_v_q, res_v_d;
  ex_t  ex_q, ex_d;
  res_t res_q, res_d;

  logic                advance;
  logic                capture;
  logic                res_load;
  logic [DATA_LEN-1:0] src_a;
  logic [DATA_LEN-1:0] src_b;
  logic [DATA_LEN-1:0] alu_res;

  assign advance       = !res_v_q | cdb_grant_i;
  assign issue_ready_o = !ex_v_q | advance;
  assign capture  = issue_valid_i & issue_ready_o & !kill_i;
  assign res_load = ex_v_q & advance & !kill_i;

  assign src_a = ex_q.src_a_sel ? ex_q.pc  : ex_q.op_1;
  assign src_b = ex_q.src_b_sel ? ex_q.imm : ex_q.op_2;

  alu_core u_alu (
    .op     (ex_q.alu_op),
    .a      (src_a),
    .b      (src_b),
    .result (alu_res)
  );

  // EX stage: capture an issue or drain into RES
  always_comb begin
    ex_v_d = ex_v_q;
    ex_d   = ex_q;
    if (kill_i) begin
      ex_v_d = 1'b0;
    end else if (capture) begin
      ex_v_d         = 1'b1;
      ex_d.pc        = issue_pc_i;
      ex_d.op_1      = issue_op_1_i;
      ex_d.op_2      = issue_op_2_i;
      ex_d.imm       = issue_imm_i;
      ex_d.src_a_sel = issue_src_a_sel_i;
      ex_d.src_b_sel = issue_src_b_sel_i;
      ex_d.alu_op    = issue_alu_op_i;
      ex_d.rrf_tag   = issue_rrf_tag_i;
      ex_d.we_dst    = issue_is_write_dst_i;
    end else if (advance) begin
      ex_v_d = 1'b0;
    end
  end

  // RES stage: load result, retire on grant
  always_comb begin
    res_v_d = res_v_q;
    res_d   = res_q;
    if (kill_i) begin
      res_v_d = 1'b0;
    end else if (res_load) begin
      res_v_d       = 1'b1;
      res_d.result  = alu_res;
      res_d.rrf_tag = ex_q.rrf_tag;
      res_d.we_dst  = ex_q.we_dst;
    end else if (cdb_grant_i & res_v_q) begin
      res_v_d = 1'b0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_v_q  <= 1'b0;
      res_v_q <= 1'b0;
      ex_q    <= '0;
      res_q   <= '0;
    end else begin
      ex_v_q  <= ex_v_d;
      res_v_q <= res_v_d;
      ex_q    <= ex_d;
      res_q   <= res_d;
    end
  end

  assign cdb_valid_o   = res_v_q;
  assign cdb_result_o  = res_q.result;
  assign cdb_rrf_tag_o = res_q.rrf_tag;
  assign cdb_we_dst_o  = res_q.we_dst;

endmodule
